// File: rtl/uncached_dbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uncached_dbus_bridge
// Description : Uncached data-bus port to valid/ready system bus bridge.
//               Stores are posted through an in-order write buffer. Loads
//               stall until the buffer has drained and read data returns,
//               so MMIO accesses keep strict program order.
// Revision    : 1.0 - initial release
// ============================================================================
module uncached_dbus_bridge #(
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uc_read,
    input  logic        uc_write,
    input  logic [31:0] uc_address,
    input  logic [3:0]  uc_byteenable,
    input  logic [31:0] uc_wrdata,
    output logic        uc_stall,
    output logic [31:0] uc_rddata,
    output logic        wb_empty,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_addr,
    output logic [3:0]  bus_req_be,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata
);

    localparam int c_ptr_w = $clog2(WB_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(WB_DEPTH);

    // A read waiting behind buffered writes simply stays in IDLE/WREQ/WRESP,
    // so no dedicated read-wait state is encoded.
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_wreq  = 3'd1;
    localparam logic [2:0] c_st_wresp = 3'd2;
    localparam logic [2:0] c_st_rreq  = 3'd4;
    localparam logic [2:0] c_st_rresp = 3'd5;
    localparam logic [2:0] c_st_rdone = 3'd6;

    logic [31:0]        r_wb_addr  [WB_DEPTH];
    logic [3:0]         r_wb_be    [WB_DEPTH];
    logic [31:0]        r_wb_wdata [WB_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    // Fullness uses the registered count only: a pop this cycle frees space next cycle.
    assign w_full = (r_count == c_full);
    assign w_push = uc_write && !uc_read && !w_full;
    assign w_pop  = (r_state == c_st_wreq) && bus_req_ready;

    // Write-buffer storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr]  <= uc_address;
            r_wb_be[r_wr_ptr]    <= uc_byteenable;
            r_wb_wdata[r_wr_ptr] <= uc_wrdata;
        end
    end

    // Circular pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bus transaction sequencer; buffered writes always go before a pending read.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_count != '0)  w_state_nxt = c_st_wreq;
                else if (uc_read)   w_state_nxt = c_st_rreq;
            end
            c_st_wreq:  if (bus_req_ready)  w_state_nxt = c_st_wresp;
            c_st_wresp: if (bus_resp_valid) w_state_nxt = c_st_idle;
            c_st_rreq:  if (bus_req_ready)  w_state_nxt = c_st_rresp;
            c_st_rresp: if (bus_resp_valid) w_state_nxt = c_st_rdone;
            c_st_rdone: w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Load data register; holds until the next read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           uc_rddata <= '0;
        else if (r_state == c_st_rresp && bus_resp_valid)  uc_rddata <= bus_resp_rdata;
    end

    // Request fields come straight from stable sources (FIFO head or held uc_* inputs).
    always_comb begin
        bus_req_valid = 1'b0;
        bus_req_write = 1'b0;
        bus_req_addr  = '0;
        bus_req_be    = '0;
        bus_req_wdata = '0;
        if (r_state == c_st_wreq) begin
            bus_req_valid = 1'b1;
            bus_req_write = 1'b1;
            bus_req_addr  = r_wb_addr[r_rd_ptr];
            bus_req_be    = r_wb_be[r_rd_ptr];
            bus_req_wdata = r_wb_wdata[r_rd_ptr];
        end else if (r_state == c_st_rreq) begin
            bus_req_valid = 1'b1;
            bus_req_addr  = uc_address;
            bus_req_be    = uc_byteenable;
        end
    end

    // Loads stall until RDONE; stores stall only against a full buffer.
    always_comb begin
        uc_stall = (uc_read && r_state != c_st_rdone) ||
                   (uc_write && !uc_read && w_full);
        wb_empty = (r_count == '0) && (r_state != c_st_wreq) && (r_state != c_st_wresp);
    end

`ifndef SYNTHESIS
    a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
        !(uc_read && uc_write));
    a_resp_only_when_waiting: assert property (@(posedge clk) disable iff (rst)
        bus_resp_valid |-> (r_state == c_st_wresp || r_state == c_st_rresp));
`endif

endmodule
`default_nettype wire

// File: tb/tb_uncached_dbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uncached_dbus_bridge
// Description : Self-checking bench for uncached_dbus_bridge. A bus slave
//               model answers requests; a queue holds the expected bus
//               request order and is checked on every accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uncached_dbus_bridge;

    localparam int WB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uc_read = 1'b0;
    logic        uc_write = 1'b0;
    logic [31:0] uc_address = '0;
    logic [3:0]  uc_byteenable = '0;
    logic [31:0] uc_wrdata = '0;
    logic        uc_stall;
    logic [31:0] uc_rddata;
    logic        wb_empty;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_write;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_be;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_resp_rdata = '0;

    uncached_dbus_bridge #(.WB_DEPTH(WB_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .uc_read        (uc_read),
        .uc_write       (uc_write),
        .uc_address     (uc_address),
        .uc_byteenable  (uc_byteenable),
        .uc_wrdata      (uc_wrdata),
        .uc_stall       (uc_stall),
        .uc_rddata      (uc_rddata),
        .wb_empty       (wb_empty),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_write  (bus_req_write),
        .bus_req_addr   (bus_req_addr),
        .bus_req_be     (bus_req_be),
        .bus_req_wdata  (bus_req_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          exp_stall;
    } vec_t;

    req_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          ready_mode = 0;   // 0 always ready, 1 never ready, 2 random
    int          resp_mode = 0;    // 0 next cycle, 1 random 0..3 extra, 2 six extra
    logic [31:0] rd_value = '0;
    bit          pending = 1'b0;
    int          dly = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus slave and request monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        req_t e;
        if (rst) begin
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            pending        = 1'b0;
        end else begin
            if (bus_resp_valid) begin
                bus_resp_valid = 1'b0;
            end else if (pending) begin
                if (dly == 0) begin
                    bus_resp_valid = 1'b1;
                    bus_resp_rdata = rd_value;
                    pending        = 1'b0;
                end else begin
                    dly--;
                end
            end
            case (ready_mode)
                0:       bus_req_ready = 1'b1;
                1:       bus_req_ready = 1'b0;
                default: bus_req_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus_req_valid && bus_req_ready) begin
                check("one_outstanding", {70'd0, pending, bus_resp_valid}, 72'd0);
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got wr=%0d addr=%h expected none",
                             bus_req_write, bus_req_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_req",
                          {3'd0, bus_req_write, bus_req_addr, bus_req_be,
                           (bus_req_write ? bus_req_wdata : 32'd0)},
                          {3'd0, e.wr, e.addr, e.be, (e.wr ? e.wdata : 32'd0)});
                end
                pending = 1'b1;
                dly = (resp_mode == 0) ? 0 : (resp_mode == 1) ? int'($urandom_range(0, 3)) : 6;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                         output int sc);
        uc_write = 1'b1; uc_address = a; uc_byteenable = be; uc_wrdata = d;
        sc = 0;
        #1;
        while (uc_stall && sc < 300) begin
            @(posedge clk);
            #2;
            sc++;
        end
        if (uc_stall) begin
            total++; bad++;
            $display("FAIL store_timeout: got stall=1 expected 0 addr=%h", a);
        end else begin
            exp_q.push_back('{1'b1, a, be, d});
        end
        @(posedge clk);
        #1;
        uc_write = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] be, input logic [31:0] rd,
                        output int lat);
        rd_value = rd;
        exp_q.push_back('{1'b0, a, be, 32'd0});
        uc_read = 1'b1; uc_address = a; uc_byteenable = be;
        lat = 0;
        #1;
        while (uc_stall && lat < 300) begin
            @(posedge clk);
            #2;
            lat++;
        end
        if (uc_stall) begin
            total++; bad++;
            $display("FAIL load_timeout: got stall=1 expected 0 addr=%h", a);
        end else begin
            check("load_rddata", {40'd0, uc_rddata}, {40'd0, rd});
        end
        @(posedge clk);
        #1;
        uc_read = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (!wb_empty && n < budget) begin
            step();
            n++;
        end
        check("wb_empty_reached", {71'd0, wb_empty}, 72'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   sc, lat, base;

        vecs[0] = '{32'h1FD0_0000, 4'b1111, 32'h1111_0000, 0};
        vecs[1] = '{32'h1FD0_0004, 4'b0001, 32'h0000_00A5, 0};
        vecs[2] = '{32'h1FD0_0008, 4'b1100, 32'hBEEF_0000, 0};
        vecs[3] = '{32'h1FD0_000C, 4'b0110, 32'h00C3_3C00, 0};

        // Reset state
        step(); step();
        check("rst_stall",   {71'd0, uc_stall},      72'd0);
        check("rst_rddata",  {40'd0, uc_rddata},     72'd0);
        check("rst_wbempty", {71'd0, wb_empty},      72'd1);
        check("rst_req",     {3'd0, bus_req_valid, bus_req_write, bus_req_addr, bus_req_be,
                              bus_req_wdata[30:0]}, 72'd0);
        rst = 1'b0;
        step();

        // Posted stores from a table, ready=1 and ack one cycle later
        ready_mode = 0; resp_mode = 0; base = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            store(vecs[i].addr, vecs[i].be, vecs[i].wdata, sc);
            check("posted_stall_cycles", 72'(sc), 72'(vecs[i].exp_stall));
        end
        check("wbempty_after_push", {71'd0, wb_empty}, 72'd0);
        wait_empty(100);
        check("posted_count", 72'(acc_cnt - base), 72'd4);
        check("posted_drained", 72'(exp_q.size()), 72'd0);

        // Full buffer with the bus refusing requests
        ready_mode = 1; base = acc_cnt;
        for (int i = 0; i < WB_DEPTH; i++) begin
            store(32'h1FD0_0040 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), sc);
            check("full_fill_stall", 72'(sc), 72'd0);
        end
        fork
            store(32'h1FD0_0050, 4'h3, 32'h5555_AAAA, sc);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #2;
                end
                check("full_stall_high", {71'd0, uc_stall}, 72'd1);
                ready_mode = 0;
            end
        join
        check("full_fifth_stalled", 72'(sc >= 3), 72'd1);
        wait_empty(100);
        check("full_count", 72'(acc_cnt - base), 72'd5);
        check("full_drained", 72'(exp_q.size()), 72'd0);

        // Read after writes: read must follow both write acks
        base = acc_cnt;
        store(32'h1FD0_0000, 4'hF, 32'h0102_0304, sc);
        store(32'h1FD0_0004, 4'hF, 32'h0506_0708, sc);
        load(32'h1FD0_0010, 4'hF, 32'hDEAD_BEEF, lat);
        check("raw_count", 72'(acc_cnt - base), 72'd3);
        check("raw_drained", 72'(exp_q.size()), 72'd0);

        // Minimum load latency on an empty buffer
        load(32'h1FD0_0014, 4'hF, 32'h1234_5678, lat);
        check("load_min_latency", 72'(lat), 72'd3);

        // Backpressure during the read request
        ready_mode = 1; base = acc_cnt;
        fork
            load(32'h1FD0_0020, 4'b0011, 32'hCAFE_F00D, lat);
            begin
                int n = 0;
                while (!bus_req_valid && n < 20) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                for (int k = 0; k < 3; k++) begin
                    check("bp_stable", {35'd0, bus_req_valid, bus_req_write, bus_req_addr, bus_req_be},
                          {35'd0, 1'b1, 1'b0, 32'h1FD0_0020, 4'b0011});
                    @(posedge clk);
                    #2;
                end
                ready_mode = 0;
            end
        join
        check("bp_single_req", 72'(acc_cnt - base), 72'd1);
        step(); step();
        check("rddata_hold", {40'd0, uc_rddata}, {40'd0, 32'hCAFE_F00D});

        // Pointer wrap with random ready and response delays
        ready_mode = 2; resp_mode = 1; base = acc_cnt;
        for (int i = 0; i < 3 * WB_DEPTH; i++) begin
            store(32'h1FD0_0100 + 32'(i * 4), 4'($urandom_range(1, 15)), $urandom, sc);
        end
        wait_empty(500);
        check("wrap_count", 72'(acc_cnt - base), 72'(3 * WB_DEPTH));
        check("wrap_drained", 72'(exp_q.size()), 72'd0);

        // Reset in the middle of a write
        ready_mode = 0; resp_mode = 2; base = acc_cnt;
        store(32'h1FD0_0200, 4'hF, 32'h7777_0000, sc);
        store(32'h1FD0_0204, 4'hF, 32'h7777_0004, sc);
        begin
            int n = 0;
            while (acc_cnt == base && n < 50) begin
                step();
                n++;
            end
        end
        check("mid_first_accept", 72'(acc_cnt - base), 72'd1);
        rst = 1'b1;
        exp_q.delete();
        step();
        check("mid_rst_wbempty", {71'd0, wb_empty},      72'd1);
        check("mid_rst_valid",   {71'd0, bus_req_valid}, 72'd0);
        check("mid_rst_stall",   {71'd0, uc_stall},      72'd0);
        rst = 1'b0;
        repeat (6) step();
        check("mid_rst_no_replay", 72'(acc_cnt - base), 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uncached_dbus_bridge.md
Name: uncached_dbus_bridge

Overview:
- Sits directly downstream of the data-bus mux, on its uncached port.
- Turns single-cycle uncached load/store requests into a valid/ready request plus response handshake toward the system bus adapter.
- Stores are posted through a small in-order write buffer. Loads stall the pipeline until the buffer drains and the read data returns, which keeps MMIO ordering strict.

Parameters:
- WB_DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- uc_read  in  1  uncached load request; held stable while uc_stall=1
- uc_write  in  1  uncached store request; held stable while uc_stall=1
- uc_address  in  32  word-aligned physical address, bits [1:0]=0
- uc_byteenable  in  4  byte lanes
- uc_wrdata  in  32  store data, already lane-shifted
- uc_stall  out  1  pipeline must hold the current request
- uc_rddata  out  32  load data; valid in the cycle uc_stall falls for a read
- wb_empty  out  1  write buffer empty and no write outstanding
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted when valid and ready
- bus_req_write  out  1  1=write, 0=read
- bus_req_addr  out  32  request address
- bus_req_be  out  4  request byte enables
- bus_req_wdata  out  32  request write data
- bus_resp_valid  in  1  response or ack; exactly one per accepted request
- bus_resp_rdata  in  32  read data, meaningful for read responses

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count cleared; FSM to IDLE.
  - All bus_req_* outputs 0; uc_stall=0; uc_rddata=0; wb_empty=1.
  - Any in-flight transaction is abandoned. The system side is reset by the same rst.
- Write buffer: circular FIFO of {addr, be, wdata}.
  - Count width is $clog2(WB_DEPTH)+1.
  - Pointers wrap modulo WB_DEPTH.
- Store path:
  - uc_write=1 with registered count<WB_DEPTH: push in that cycle, uc_stall=0 combinationally.
  - With count==WB_DEPTH: uc_stall=1, no push; retried each cycle.
  - No full-bypass: a pop in the same cycle does not free space until the next cycle.
- At most one bus transaction is outstanding.
- Bus FSM states: IDLE, WREQ, WRESP, RWAIT, RREQ, RRESP, RDONE.
  - IDLE: if FIFO non-empty, go to WREQ. Otherwise, if uc_read=1, go to RREQ.
  - WREQ: bus_req_valid=1, write=1, fields from the FIFO head. On ready, pop the head and go to WRESP.
  - WRESP: on bus_resp_valid, go to IDLE.
  - RREQ: bus_req_valid=1, write=0, addr/be from uc_*. On ready, go to RRESP.
  - RRESP: on bus_resp_valid, capture rdata into uc_rddata register and go to RDONE.
  - RDONE: uc_stall=0 for exactly one cycle, then return to IDLE.
  - RWAIT is folded in: a read stays pending in IDLE/WREQ/WRESP until the FIFO is empty.
- uc_stall for loads: 1 from the first cycle uc_read=1 until RDONE. Zero-latency loads never occur; minimum load latency is 3 cycles with ready and resp immediate.
- Stores pushed while a read is pending cannot happen, because the pipeline is stalled.
- Reads are never reordered ahead of buffered writes.
- bus_req_* fields stay stable while valid=1 and ready=0; valid never drops before acceptance.
- uc_read and uc_write both 1 in the same cycle is illegal; an assertion fires. The bridge treats it as read-priority with the store ignored.
- bus_resp_valid outside WRESP/RRESP is illegal; it is ignored and an assertion fires.
- wb_empty = (count==0) && state not in {WREQ, WRESP}. It is used by SYNC handling.
- uc_rddata holds its last value until the next read response.

Test Plan:
- Reset mid-write: push 2 stores, assert rst while in WRESP → next cycle wb_empty=1, bus_req_valid=0, uc_stall=0.
- Posted stores: 4 stores to 0x1FD0_0000..0x1FD0_000C, ready=1, resp 1 cycle later.
  - All 4 accepted with uc_stall=0.
  - 4 bus writes issued in order with matching be/wdata.
  - wb_empty rises after the 4th ack.
- Full buffer: 5 back-to-back stores with bus_req_ready=0 → uc_stall=1 on the 5th until the first pop, then 5th pushed. Total of 5 writes issued in order.
- Read after writes: 2 stores, then a load from 0x1FD0_0010 → read request issued only after the 2nd write ack. With bus_resp_rdata=0xDEADBEEF, uc_rddata=0xDEADBEEF in the cycle uc_stall falls.
- Backpressure: hold bus_req_ready=0 for 3 cycles during RREQ → address, be and valid stable throughout. One request only; response delivered; uc_stall low for exactly one cycle.
- Pointer wrap: 3×WB_DEPTH stores with random ready/resp delays → FIFO wraps, bus order equals push order, no lost or duplicated entries.
